// File: rtl/wbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wbus_arbiter
// Purpose  : Round-robin arbiter and transfer sequencer for the shared W bus.
//            Drives one source enable and one active-low destination load per
//            transfer, with a turnaround cycle between owners.
// Revision : 1.0  initial release
// ============================================================================
module wbus_arbiter #(
    parameter int NREQ      = 4,
    parameter int NDST      = 8,
    parameter int DST_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           lock,
    input  logic [NREQ*DST_W-1:0]     dst,
    output logic [NREQ-1:0]           E,
    output logic [NDST-1:0]           nL,
    output logic [NREQ-1:0]           ack,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output logic                      err
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_TURN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [NREQ-1:0] e_q, e_d;
    logic [NREQ-1:0] ack_q;
    logic [NDST-1:0] nl_q, nl_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic            arb_found;
    logic [IW-1:0]   arb_win;
    logic            do_grant;
    logic [IW-1:0]   sel;
    logic [DST_W-1:0] sel_dst;

    // First requester at or after the rotating pointer wins.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!arb_found && req[(int'(ptr_q) + k) % NREQ]) begin
                arb_found = 1'b1;
                arb_win   = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        burst_d  = burst_q;
        do_grant = 1'b0;
        sel      = gnt_q;
        case (state_q)
            S_XFER: begin
                if (req[gnt_q] && lock[gnt_q] && (int'(burst_q) < MAX_BURST)) begin
                    do_grant = 1'b1;
                    burst_d  = burst_q + BW'(1);
                end else begin
                    state_d = S_TURN;
                end
            end
            default: begin
                if (arb_found) begin
                    state_d  = S_XFER;
                    do_grant = 1'b1;
                    sel      = arb_win;
                    gnt_d    = arb_win;
                    burst_d  = BW'(1);
                    ptr_d    = (int'(arb_win) + 1 == NREQ) ? '0 : arb_win + IW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        sel_dst = dst[int'(sel)*DST_W +: DST_W];
        e_d     = '0;
        nl_d    = '1;
        err_d   = 1'b0;
        if (do_grant) begin
            e_d[sel] = 1'b1;
            // Out-of-range ids still run the source cycle but load nothing.
            err_d    = (int'(sel_dst) >= NDST);
            for (int d = 0; d < NDST; d++) begin
                if (int'(sel_dst) == d) begin
                    nl_d[d] = 1'b0;
                end
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            burst_q <= '0;
            e_q     <= '0;
            ack_q   <= '0;
            nl_q    <= '1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            burst_q <= burst_d;
            e_q     <= e_d;
            ack_q   <= e_d;
            nl_q    <= nl_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign E      = e_q;
    assign ack    = ack_q;
    assign nL     = nl_q;
    assign gnt_id = gnt_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbus_arbiter
// Purpose  : Directed self-checking bench for wbus_arbiter (NDST=8 and NDST=6).
// Revision : 1.0  initial release
// ============================================================================
module tb_wbus_arbiter;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [11:0] dst;
    logic [3:0]  E, ack, E6, ack6;
    logic [7:0]  nL;
    logic [5:0]  nL6;
    logic [1:0]  gnt_id, gnt6;
    logic        busy, err, busy6, err6;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] e;
        logic [7:0] nl;
        logic [3:0] a;
        logic       b;
        logic       er;
        logic [1:0] g;
    } exp_t;

    exp_t sb[$];

    wbus_arbiter #(.NREQ(4), .NDST(8), .DST_W(3), .MAX_BURST(4)) u_dut (
        .CLK(CLK), .CLR(CLR), .req(req), .lock(lock), .dst(dst),
        .E(E), .nL(nL), .ack(ack), .gnt_id(gnt_id), .busy(busy), .err(err)
    );

    wbus_arbiter #(.NREQ(4), .NDST(6), .DST_W(3), .MAX_BURST(4)) u_dut6 (
        .CLK(CLK), .CLR(CLR), .req(req), .lock(lock), .dst(dst),
        .E(E6), .nL(nL6), .ack(ack6), .gnt_id(gnt6), .busy(busy6), .err(err6)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dst(input int i, input int v);
        logic [2:0] t;
        t = 3'(v);
        dst[i*3 +: 3] = t;
    endtask

    // Queue the expectation for the next edge, then compare once outputs settle.
    task automatic cyc(input string tag, input logic [3:0] e, input logic [7:0] nl,
                       input logic b, input logic er, input logic [1:0] g);
        exp_t x, y;
        x.e = e; x.nl = nl; x.a = e; x.b = b; x.er = er; x.g = g;
        sb.push_back(x);
        @(posedge CLK);
        #1;
        y = sb.pop_front();
        chk({tag, ".E"},    32'(E),      32'(y.e));
        chk({tag, ".nL"},   32'(nL),     32'(y.nl));
        chk({tag, ".ack"},  32'(ack),    32'(y.a));
        chk({tag, ".busy"}, 32'(busy),   32'(y.b));
        chk({tag, ".err"},  32'(err),    32'(y.er));
        chk({tag, ".gnt"},  32'(gnt_id), 32'(y.g));
    endtask

    initial begin
        CLR = 1'b1; req = 4'b1111; lock = 4'b0000; dst = '0;

        // Reset held with all requests active
        cyc("rst0", 4'b0000, 8'hFF, 1'b0, 1'b0, 2'd0);
        cyc("rst1", 4'b0000, 8'hFF, 1'b0, 1'b0, 2'd0);
        CLR = 1'b0; req = 4'b0000;
        cyc("idle", 4'b0000, 8'hFF, 1'b0, 1'b0, 2'd0);

        // Single transfer from IDLE
        req = 4'b0001; set_dst(0, 3);
        cyc("single.x", 4'b0001, 8'b1111_0111, 1'b1, 1'b0, 2'd0);
        req = 4'b0000;
        cyc("single.t", 4'b0000, 8'hFF, 1'b1, 1'b0, 2'd0);
        cyc("single.i", 4'b0000, 8'hFF, 1'b0, 1'b0, 2'd0);

        // Round robin from a fresh pointer
        CLR = 1'b1;
        cyc("rr.rst", 4'b0000, 8'hFF, 1'b0, 1'b0, 2'd0);
        CLR = 1'b0;
        set_dst(0, 3); set_dst(1, 1); set_dst(2, 4); set_dst(3, 6);
        req = 4'b1111;
        cyc("rr.g0",  4'b0001, 8'b1111_0111, 1'b1, 1'b0, 2'd0);
        cyc("rr.t0",  4'b0000, 8'hFF,        1'b1, 1'b0, 2'd0);
        cyc("rr.g1",  4'b0010, 8'b1111_1101, 1'b1, 1'b0, 2'd1);
        cyc("rr.t1",  4'b0000, 8'hFF,        1'b1, 1'b0, 2'd1);
        cyc("rr.g2",  4'b0100, 8'b1110_1111, 1'b1, 1'b0, 2'd2);
        cyc("rr.t2",  4'b0000, 8'hFF,        1'b1, 1'b0, 2'd2);
        cyc("rr.g3",  4'b1000, 8'b1011_1111, 1'b1, 1'b0, 2'd3);
        cyc("rr.t3",  4'b0000, 8'hFF,        1'b1, 1'b0, 2'd3);
        cyc("rr.g0b", 4'b0001, 8'b1111_0111, 1'b1, 1'b0, 2'd0);
        req = 4'b0000;
        cyc("rr.t4",  4'b0000, 8'hFF,        1'b1, 1'b0, 2'd0);
        cyc("rr.i",   4'b0000, 8'hFF,        1'b0, 1'b0, 2'd0);

        // Locked burst capped at four transfers
        req = 4'b0100; lock = 4'b0100; set_dst(2, 1);
        cyc("bu.1", 4'b0100, 8'b1111_1101, 1'b1, 1'b0, 2'd2);
        set_dst(2, 2);
        cyc("bu.2", 4'b0100, 8'b1111_1011, 1'b1, 1'b0, 2'd2);
        set_dst(2, 5);
        cyc("bu.3", 4'b0100, 8'b1101_1111, 1'b1, 1'b0, 2'd2);
        set_dst(2, 6);
        cyc("bu.4", 4'b0100, 8'b1011_1111, 1'b1, 1'b0, 2'd2);
        set_dst(2, 7);
        cyc("bu.cap", 4'b0000, 8'hFF,      1'b1, 1'b0, 2'd2);
        cyc("bu.5", 4'b0100, 8'b0111_1111, 1'b1, 1'b0, 2'd2);
        req = 4'b0000; lock = 4'b0000;
        cyc("bu.t", 4'b0000, 8'hFF,        1'b1, 1'b0, 2'd2);
        cyc("bu.i", 4'b0000, 8'hFF,        1'b0, 1'b0, 2'd2);

        // Id 7 is valid on the 8-destination bus, invalid on the 6-destination bus
        req = 4'b0010; set_dst(1, 7);
        cyc("inv.x", 4'b0010, 8'b0111_1111, 1'b1, 1'b0, 2'd1);
        chk("inv6.E",   32'(E6),   32'h2);
        chk("inv6.ack", 32'(ack6), 32'h2);
        chk("inv6.nL",  32'(nL6),  32'h3F);
        chk("inv6.err", 32'(err6), 32'h1);
        req = 4'b0000;
        cyc("inv.t", 4'b0000, 8'hFF, 1'b1, 1'b0, 2'd1);
        chk("inv6.err_pulse", 32'(err6), 32'h0);
        chk("inv6.busy",      32'(busy6), 32'h1);
        cyc("inv.i", 4'b0000, 8'hFF, 1'b0, 1'b0, 2'd1);

        // Reset in the middle of a locked burst clears the pointer
        req = 4'b0001; lock = 4'b0001; set_dst(0, 0);
        cyc("mb.1", 4'b0001, 8'b1111_1110, 1'b1, 1'b0, 2'd0);
        set_dst(0, 1);
        cyc("mb.2", 4'b0001, 8'b1111_1101, 1'b1, 1'b0, 2'd0);
        CLR = 1'b1;
        cyc("mb.rst", 4'b0000, 8'hFF, 1'b0, 1'b0, 2'd0);
        CLR = 1'b0; lock = 4'b0000; req = 4'b1001; set_dst(0, 2); set_dst(3, 5);
        cyc("mb.g0", 4'b0001, 8'b1111_1011, 1'b1, 1'b0, 2'd0);
        req = 4'b1000;
        cyc("mb.t0", 4'b0000, 8'hFF,        1'b1, 1'b0, 2'd0);
        cyc("mb.g3", 4'b1000, 8'b1101_1111, 1'b1, 1'b0, 2'd3);
        req = 4'b0000;
        cyc("mb.t3", 4'b0000, 8'hFF,        1'b1, 1'b0, 2'd3);
        cyc("mb.i",  4'b0000, 8'hFF,        1'b0, 1'b0, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
